// File: rtl/prefetch_fetcher.sv
// prefetch_fetcher
//   Instruction fetcher with a small prefetch queue. A single-outstanding
//   read engine streams sequential instructions from program memory into a
//   FIFO of {address tag, instruction} entries. When the core asks for a PC,
//   the queue head is delivered if its tag matches. Otherwise the queue is
//   flushed and prefetching restarts at the requested PC.
//
// Parameters
//   PROGRAM_MEM_ADDR_BITS  program address width (also the width of current_pc)
//   PROGRAM_MEM_DATA_BITS  instruction width
//   QUEUE_DEPTH            queue entries, power of 2, >= 2
//
// Ports
//   clk, reset         clock (rising edge), synchronous active-high reset
//   core_state         3'b001 = FETCH request, 3'b010 = DECODE (release)
//   current_pc         PC the core wants delivered
//   mem_read_valid     read request, held until mem_read_ready
//   mem_read_address   address of the read request
//   mem_read_ready     request accepted / data valid this cycle
//   mem_read_data      returned instruction
//   fetcher_state      IDLE 000, FETCHING 001, FETCHED 010
//   instruction        last delivered instruction
//   queue_count        number of valid queue entries
//   flush_count        number of queue flushes
//   hit_count          deliveries made in the first FETCHING cycle
//
// Configuration
//   PREFETCH_FETCHER_STATS_EN  when defined, flush_count and hit_count are
//                              live 32-bit wrapping counters. Otherwise both
//                              are tied to zero.
module prefetch_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int QUEUE_DEPTH           = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [2:0]                           core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0]     current_pc,
    output logic                                 mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]     mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0]     mem_read_data,
    output logic [2:0]                           fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0]     instruction,
    output logic [$clog2(QUEUE_DEPTH):0]         queue_count,
    output logic [31:0]                          flush_count,
    output logic [31:0]                          hit_count
);

    localparam int A     = PROGRAM_MEM_ADDR_BITS;
    localparam int D     = PROGRAM_MEM_DATA_BITS;
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(QUEUE_DEPTH);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        FETCHING = 3'b001,
        FETCHED  = 3'b010
    } state_t;

    state_t state, state_next;

    logic [A-1:0]     tag_mem  [QUEUE_DEPTH];
    logic [D-1:0]     data_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic [A-1:0]     prefetch_pc;
    logic             outstanding;
    logic             discard;      // in-flight read belongs to a flushed stream

    logic queue_empty, head_match;
    logic hit, flush, accept, push, issue;

    assign queue_empty = (count == '0);
    assign head_match  = (tag_mem[rd_ptr] == current_pc);

    // Next state and the per-cycle hit/flush decisions
    always_comb begin
        state_next = state;
        hit        = 1'b0;
        flush      = 1'b0;
        unique case (state)
            IDLE: begin
                if (core_state == 3'b001) state_next = FETCHING;
            end
            FETCHING: begin
                if (!queue_empty) begin
                    if (head_match) begin
                        hit        = 1'b1;
                        state_next = FETCHED;
                    end else begin
                        flush = 1'b1;
                    end
                end else if (!outstanding && prefetch_pc != current_pc) begin
                    // Empty queue and nothing in flight, but the stream
                    // points elsewhere: redirect now instead of waiting.
                    flush = 1'b1;
                end
            end
            FETCHED: begin
                if (core_state == 3'b010) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = outstanding && mem_read_ready;
    // A read completing in a flush cycle belongs to the old stream.
    assign push   = accept && !discard && !flush;
    // No issue in a flush cycle: prefetch_pc is about to be redirected.
    assign issue  = !outstanding && !flush && (count < DEPTH_CNT);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Queue storage has no reset; entries are only read when count > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr]  <= mem_read_address;
            data_mem[wr_ptr] <= mem_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding      <= 1'b0;
            discard          <= 1'b0;
            mem_read_address <= '0;
            prefetch_pc      <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            instruction      <= '0;
        end else begin
            if (accept) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
                // A discarded read must not advance the redirected stream.
                if (!discard) prefetch_pc <= prefetch_pc + 1'b1;
            end else if (issue) begin
                outstanding      <= 1'b1;
                mem_read_address <= prefetch_pc;
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;

            if (hit) begin
                rd_ptr      <= rd_ptr + 1'b1;
                instruction <= data_mem[rd_ptr];
            end

            if (push && !hit)      count <= count + 1'b1;
            else if (hit && !push) count <= count - 1'b1;

            // Flush overrides the queue and stream updates above.
            if (flush) begin
                prefetch_pc <= current_pc;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                discard     <= outstanding && !accept;
            end
        end
    end

    assign mem_read_valid = outstanding;
    assign fetcher_state  = state;
    assign queue_count    = count;

`ifdef PREFETCH_FETCHER_STATS_EN
    logic        first_cycle;   // high during the first FETCHING cycle
    logic [31:0] flush_cnt, hit_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            first_cycle <= 1'b0;
            flush_cnt   <= '0;
            hit_cnt     <= '0;
        end else begin
            first_cycle <= (state == IDLE) && (state_next == FETCHING);
            if (flush)              flush_cnt <= flush_cnt + 1'b1;
            if (hit && first_cycle) hit_cnt   <= hit_cnt + 1'b1;
        end
    end

    assign flush_count = flush_cnt;
    assign hit_count   = hit_cnt;
`else
    assign flush_count = '0;
    assign hit_count   = '0;
`endif

endmodule

// File: tb/tb_prefetch_fetcher.sv
// Testbench for prefetch_fetcher. A memory responder returns addr + 0x100
// after a programmable latency. The expected instruction, flush count and
// request order come from a stream-level model. That model tracks the next
// sequential PC the fetcher should already hold: a fetch of any other PC
// costs exactly one flush.
module tb_prefetch_fetcher;
    localparam int A  = 8;
    localparam int D  = 16;
    localparam int QD = 4;
`ifdef PREFETCH_FETCHER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    core_state;
    logic [A-1:0]  current_pc;
    logic          mem_read_valid;
    logic [A-1:0]  mem_read_address;
    logic          mem_read_ready;
    logic [D-1:0]  mem_read_data;
    logic [2:0]    fetcher_state;
    logic [D-1:0]  instruction;
    logic [2:0]    queue_count;
    logic [31:0]   flush_count;
    logic [31:0]   hit_count;

    logic resp_ready, late_ready;
    assign mem_read_ready = resp_ready | late_ready;

    always #5 clk = ~clk;

    prefetch_fetcher #(.PROGRAM_MEM_ADDR_BITS(A), .PROGRAM_MEM_DATA_BITS(D), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .fetcher_state(fetcher_state), .instruction(instruction),
        .queue_count(queue_count), .flush_count(flush_count), .hit_count(hit_count)
    );

    int vectors = 0;
    int errors  = 0;

    // Memory responder controls
    int           lat      = 1;
    bit           rand_lat = 1'b0;
    bit           mem_hold = 1'b0;
    logic [A-1:0] req_log[$];   // addresses in acceptance order

    // Reference model
    logic [A-1:0] exp_next;
    int           exp_flush;

    // Protocol-monitor history
    logic pv = 1'b0, pr = 1'b0;
    logic [A-1:0] pa = '0;
    logic rst_at_edge = 1'b1;
    always @(posedge clk) rst_at_edge <= reset;

    initial begin
        int wait_cnt;
        int rlat;
        wait_cnt      = 0;
        rlat          = 0;
        resp_ready    = 1'b0;
        mem_read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_ready) begin
                resp_ready = 1'b0;
                wait_cnt   = 0;
                rlat       = $urandom_range(0, 3);
            end else if (mem_read_valid && !mem_hold && !reset) begin
                if (wait_cnt >= (rand_lat ? rlat : lat)) begin
                    resp_ready    = 1'b1;
                    mem_read_data = 16'h0100 + 16'(mem_read_address);
                    req_log.push_back(mem_read_address);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle, sampled at the falling edge, with continuous protocol checks
    task automatic step();
        @(negedge clk);
        check("queue_bound", 32'(queue_count <= 3'(QD)), 1);
        if (!rst_at_edge && pv && !pr) begin
            check("valid_held", 32'(mem_read_valid), 1);
            check("addr_held", 32'(mem_read_address), 32'(pa));
        end
        pv = mem_read_valid;
        pr = mem_read_ready;
        pa = mem_read_address;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic fetch(input logic [A-1:0] pc, input bit chk_lat);
        int cyc;
        bit done;
        step();
        core_state = 3'b001;
        current_pc = pc;
        if (pc != exp_next) exp_flush++;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 300) begin
            step();
            cyc++;
            if (fetcher_state == 3'b010) done = 1'b1;
        end
        check("fetched_reached", 32'(done), 1);
        if (chk_lat) check("hit_latency", 32'(cyc), 2);
        check("instruction", 32'(instruction), 32'h100 + 32'(pc));
        check("flush_count", flush_count, STATS ? 32'(exp_flush) : 32'd0);
        exp_next   = pc + 8'd1;
        core_state = 3'b010;
        step();
        check("back_to_idle", 32'(fetcher_state), 0);
        core_state = 3'b000;
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (req_log.size() > i) return 32'(req_log[i]);
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        int k;
        reset      = 1'b1;
        core_state = 3'b000;
        current_pc = '0;
        late_ready = 1'b0;
        idle(3);
        check("rst_state", 32'(fetcher_state), 0);
        check("rst_valid", 32'(mem_read_valid), 0);
        check("rst_addr", 32'(mem_read_address), 0);
        check("rst_instr", 32'(instruction), 0);
        check("rst_qcount", 32'(queue_count), 0);
        check("rst_flush", flush_count, 0);
        check("rst_hit", hit_count, 0);
        reset     = 1'b0;
        exp_next  = '0;
        exp_flush = 0;

        // Sequential stream with a full queue before each fetch
        idle(40);
        check("queue_full", 32'(queue_count), QD);
        for (int i = 0; i < 8; i++) begin
            fetch(8'(i), 1'b1);
            idle(40);
        end
        check("hit_count_seq", hit_count, STATS ? 32'd8 : 32'd0);

        // Redirect while a slow read is outstanding: its data is dropped
        lat = 5;
        fetch(8'h08, 1'b1);      // pops 8, slow read of 0x0C starts
        req_log.delete();
        fetch(8'h40, 1'b0);
        idle(20);
        check("discard_old_req", log_at(0), 32'h0C);
        check("discard_next_req", log_at(1), 32'h40);
        lat = 1;
        idle(40);

        // Branch from a full queue
        req_log.delete();
        fetch(8'h20, 1'b0);
        check("branch_first_req", log_at(0), 32'h20);
        idle(40);

        // Address wrap
        req_log.delete();
        fetch(8'hFE, 1'b0);
        idle(40);
        check("wrap_req0", log_at(0), 32'hFE);
        check("wrap_req1", log_at(1), 32'hFF);
        check("wrap_req2", log_at(2), 32'h00);
        check("wrap_req3", log_at(3), 32'h01);
        fetch(8'hFF, 1'b1);
        idle(40);
        fetch(8'h00, 1'b1);
        idle(10);

        // Reset during an outstanding read, late ready afterwards
        mem_hold = 1'b1;
        fetch(8'h01, 1'b1);
        k = 0;
        while (!mem_read_valid && k < 20) begin
            step();
            k++;
        end
        check("valid_before_reset", 32'(mem_read_valid), 1);
        reset = 1'b1;
        step();
        check("midrst_valid", 32'(mem_read_valid), 0);
        check("midrst_addr", 32'(mem_read_address), 0);
        check("midrst_state", 32'(fetcher_state), 0);
        check("midrst_instr", 32'(instruction), 0);
        check("midrst_qcount", 32'(queue_count), 0);
        check("midrst_flush", flush_count, 0);
        check("midrst_hit", hit_count, 0);
        step();
        reset      = 1'b0;
        late_ready = 1'b1;
        step();
        late_ready = 1'b0;
        check("late_ready_qcount", 32'(queue_count), 0);
        step();
        check("late_ready_qcount2", 32'(queue_count), 0);
        mem_hold  = 1'b0;
        exp_next  = '0;
        exp_flush = 0;

        // Random PCs and memory latencies
        rand_lat = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [A-1:0] pc;
            pc = ($urandom_range(0, 1) == 1) ? exp_next : 8'($urandom_range(0, 255));
            fetch(pc, 1'b0);
            idle($urandom_range(0, 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
